// File: rtl/parity_rr_scheduler_pkg.sv
// Shared types and the round-robin pick function for the parity scheduler.
// rr_pick searches at most RR_MAX requesters starting at ptr, wrapping modulo nreq.
package parity_pkg;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  typedef logic [0:0] state_t;
  localparam state_t EMPTY = 1'b0;
  localparam state_t FULL  = 1'b1;

  localparam int RR_MAX   = 16;
  localparam int RR_IDX_W = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                    input logic [RR_IDX_W-1:0] ptr,
                                    input int                  nreq);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (k < nreq && !p.found && valid[idx[RR_IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = idx[RR_IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/parity_rr_scheduler_if.sv
// Request/response bundle between the producers (master) and the scheduler (slave).
interface parity_rr_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_parity;
  logic [ID_W-1:0]        rsp_id;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_parity, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_parity, rsp_id
  );
endinterface

// File: rtl/parity_rr_scheduler_xor_tree.sv
// Combinational parity of one word; ODD selects an inverted (odd) parity bit.
module parity_xor_tree
  import parity_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ODD    = PAR_EVEN
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);
  assign parity_o = (^data_i) ^ (ODD == PAR_ODD);
endmodule

// File: rtl/parity_rr_scheduler.sv
// Round-robin shares one parity datapath between NREQ requesters.
// One registered response slot; a new grant may load while the old one drains.
module parity_rr_scheduler
  import parity_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ODD    = PAR_EVEN
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_rr_scheduler_if.slave  bus
);
  localparam int ID_W = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_parity_q, rsp_parity_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic [RR_MAX-1:0] valid_ext;
  pick_t             pick;
  logic              can_accept;
  logic              grant;
  logic [ID_W-1:0]   win_idx;
  logic [DATA_W-1:0] win_word;
  logic              win_parity;

  always_comb begin
    valid_ext = '0;
    valid_ext[NREQ-1:0] = bus.req_valid;
  end

  assign pick       = rr_pick(valid_ext, RR_IDX_W'(rr_ptr_q), NREQ);
  assign win_idx    = pick.idx[ID_W-1:0];
  assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
  assign grant      = pick.found && can_accept && !rst;
  assign win_word   = bus.req_data[win_idx*DATA_W +: DATA_W];

  parity_xor_tree #(
    .DATA_W (DATA_W),
    .ODD    (ODD)
  ) u_xor_tree (
    .data_i   (win_word),
    .parity_o (win_parity)
  );

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_data_d   = rsp_data_q;
    rsp_parity_d = rsp_parity_q;
    rsp_id_d     = rsp_id_q;
    if (grant) begin
      state_d      = FULL;
      rsp_data_d   = win_word;
      rsp_parity_d = win_parity;
      rsp_id_d     = win_idx;
      rr_ptr_d     = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (state_q == FULL && bus.rsp_ready) begin
      // Drained with nothing to replace it; payload fields keep their last value.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      rr_ptr_q     <= '0;
      rsp_data_q   <= '0;
      rsp_parity_q <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_parity_q <= rsp_parity_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.rsp_valid  = (state_q == FULL);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_parity = rsp_parity_q;
  assign bus.rsp_id     = rsp_id_q;
endmodule

// File: doc/parity_rr_scheduler.md
Name: parity_rr_scheduler

Overview:
Shares one parity-generation datapath between NREQ requesters. Each requester presents a DATA_W-bit word under a valid/ready handshake. The block grants one requester per cycle using round-robin arbitration, computes that word's parity, and returns data, parity and requester ID through a single registered, back-pressurable response port. It sits between multiple producers (e.g. lane framers) and a single downstream checker or serializer.

Parameters:
NREQ, 4, number of requesters (2..16)
DATA_W, 32, word width in bits
ODD, 0, 0 = even parity (bit = XOR of data); 1 = odd parity (bit = inverted XOR)
ID_W, $clog2(NREQ), width of the requester ID (derived, not overridden)

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester word-valid
req_data  input  NREQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NREQ  one-hot grant; a word is taken when req_valid[i] & req_ready[i] are both 1
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  downstream accepts the response
rsp_data  output  DATA_W  captured word
rsp_parity  output  1  parity of rsp_data, per ODD
rsp_id  output  ID_W  index of the requester that supplied rsp_data

Behaviour:
- Reset (rst=1 at a clk edge): rsp_valid=0, rsp_data=0, rsp_parity=0, rsp_id=0, rr_ptr=0. While rst=1, req_ready=0. Reset mid-transaction drops the held response with no completion.
- FSM has two states:
  - EMPTY: response register free.
  - FULL: response register holds a result and rsp_valid=1.
- can_accept = (state==EMPTY) | (state==FULL & rsp_ready).
- Arbitration is combinational:
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit is the winner.
  - req_ready is one-hot at the winner only when can_accept=1 and rst=0; otherwise it is all zeros.
  - req_ready never asserts for a requester whose req_valid is 0.
- On a grant at edge t:
  - rsp_data <= winner word; rsp_parity <= ^word ^ ODD; rsp_id <= winner index.
  - State -> FULL; rr_ptr <= (winner+1) mod NREQ.
  - Latency is 1 cycle: rsp_valid is high in the cycle after req_ready.
- FULL & rsp_ready=1 & a grant in the same cycle: the old response completes and the new one loads in that cycle. Throughput is one word per cycle.
- FULL & rsp_ready=1 & no request: state -> EMPTY, rsp_valid -> 0. rsp_data, rsp_parity and rsp_id hold their last values.
- FULL & rsp_ready=0: all rsp_* outputs are held stable; req_ready is all zeros; rr_ptr is unchanged.
- No request while EMPTY: nothing changes, including rr_ptr.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NREQ-1,0.
- A requester that drops valid before being granted loses nothing. The pointer advances only on a grant.

Decomposition:
- Shared package parity_pkg holds:
  - the ODD/EVEN localparam encodings;
  - the state typedef {EMPTY, FULL};
  - a function rr_pick(valid, ptr) returning the winner index plus a found flag.
- One sub-module, parity_xor_tree: a combinational DATA_W-input XOR reduction with an ODD-select inversion. The scheduler instantiates exactly one.

Test Plan:
- Reset mid-FULL: load 32'd128, then assert rst one cycle with rsp_ready=0 -> next cycle rsp_valid=0, rsp_data=0, rsp_parity=0, req_ready=0 during rst.
- Single requester, ODD=0: req1 presents 32'd0, 32'd128, 32'd254, 32'd439, 32'd369, 32'd711 back-to-back, rsp_ready=1 -> responses appear one cycle after each accept with rsp_id=1 and parity 0,1,1,1,1,0; one word per cycle.
- ODD=1 build with the same sequence -> parity 1,0,0,0,0,1.
- Round-robin with NREQ=4, all valid, distinct data (req i = 32'd(i+1)), rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3.
- Back-pressure: hold rsp_ready=0 for 5 cycles while FULL with 32'd711 -> rsp_* stable, rsp_parity=0, req_ready all zeros, rr_ptr frozen. Release -> next grant goes to the requester following the last winner.
- Sparse/wrap: rr_ptr=3, only req0 and req2 valid -> req0 granted first (wrap), then req2. A requester that drops valid before grant never appears on rsp_id.
